locked_reg_bank: RTL and testbench
==================================

LOCKED_REG_BANK -- requirements
Module: locked_reg_bank

Interface
REQ-001 SHALL have parameter WIDTH, 8, data width of each register.
REQ-002 SHALL have parameter NUM_REGS, 4, register count (power of two, >= 2); AW = $clog2(NUM_REGS).
REQ-003 SHALL have parameter KEY0, 8'hA5, first unlock key word (WIDTH bits).
REQ-004 SHALL have parameter KEY1, 8'h3C, second unlock key word (WIDTH bits).
REQ-005 SHALL have parameter LOCKOUT_CYCLES, 16, penalty cycles after a wrong key (>= 1).
REQ-006 SHALL have port clk  input  1  rising-edge clock.
REQ-007 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-008 SHALL have port wr_en  input  1  register write request.
REQ-009 SHALL have port wr_addr  input  AW  register write index.
REQ-010 SHALL have port wr_data  input  WIDTH  register write data.
REQ-011 SHALL have port lock_set  input  NUM_REGS  per-register sticky lock request.
REQ-012 SHALL have port key_valid  input  1  key word strobe.
REQ-013 SHALL have port key_data  input  WIDTH  key word.
REQ-014 SHALL have port regs_q  output  NUM_REGS*WIDTH  register contents; register i occupies bits [i*WIDTH +: WIDTH].
REQ-015 SHALL have port lock_q  output  NUM_REGS  current lock bit per register (1 = locked).
REQ-016 SHALL have port wr_err  output  1  one-cycle pulse: write rejected.
REQ-017 SHALL have port unlock_state  output  2  current FSM state encoding.

Function
REQ-018 SHALL accept a write when wr_en=1 and lock_q[wr_addr]=0, updating the register on the next rising edge.
REQ-019 SHALL, for wr_en=1 with lock_q[wr_addr]=1, leave the register unchanged and assert wr_err on the next cycle for exactly one cycle.
REQ-020 SHALL set lock_q[i] on the edge after lock_set[i]=1; the bit stays set until reset or an unlock event.
REQ-021 SHALL, when lock_set[wr_addr]=1 and wr_en=1 fall in the same cycle on an unlocked register, accept the write and set the lock bit on that same edge.
REQ-022 SHALL implement the unlock FSM with states S_IDLE=2'd0, S_KEY0_OK=2'd1, S_LOCKOUT=2'd2, S_UNLOCKED=2'd3.
REQ-023 SHALL transition S_IDLE->S_KEY0_OK on key_valid with key_data==KEY0, and S_IDLE->S_LOCKOUT on key_valid with any other value.
REQ-024 SHALL transition S_KEY0_OK->S_UNLOCKED on key_valid with key_data==KEY1, and S_KEY0_OK->S_LOCKOUT on key_valid with any other value; with no key_valid it holds.
REQ-025 SHALL, on entry to S_UNLOCKED, clear all lock_q bits on that edge; S_UNLOCKED returns to S_IDLE on the next cycle.
REQ-026 SHALL give lock_set priority over the unlock clear for the same bit in the same cycle.
REQ-027 SHALL load a lockout counter with LOCKOUT_CYCLES-1 on entry to S_LOCKOUT, decrement it each cycle, ignore key_valid throughout, and return to S_IDLE when the counter reads 0.
REQ-028 SHALL size the counter as $clog2(LOCKOUT_CYCLES+1) bits with no wrap below 0.

Reset
REQ-029 SHALL, on reset, set all regs_q to 0, all lock_q to 1 (secure default: locked), wr_err to 0, unlock_state to S_IDLE, and the lockout counter to 0.
REQ-030 SHALL have no storage element whose value is undefined after reset; reset overrides every concurrent input, including an in-progress lockout or key sequence.

Structure
REQ-031 SHALL place the FSM state enum typedef and its encodings in shared package locked_reg_pkg.
REQ-032 SHALL implement the key FSM and lockout counter in sub-module unlock_fsm, which outputs a one-cycle unlock_pulse and the state.

Verification
REQ-033 SHALL cover: reset, then write 8'h11 to reg 0 -> reg 0 stays 0, wr_err pulses once, lock_q=4'hF.
REQ-034 SHALL cover: keys A5 then 3C -> unlock_state passes 1, 3, 0; lock_q=4'h0; a write of 8'h22 to reg 2 then lands.
REQ-035 SHALL cover: keys A5 then 00 -> S_LOCKOUT for exactly 16 cycles; A5 presented during lockout is ignored; then S_IDLE.
REQ-036 SHALL cover: after unlock, lock_set=4'b0010 with write 8'h7E to reg 1 in the same cycle -> reg 1=8'h7E and lock_q[1]=1; a following write to reg 1 is rejected with wr_err.
REQ-037 SHALL cover: reset asserted mid-lockout and mid-key-sequence -> next cycle all locks=1, regs=0, state S_IDLE.
REQ-038 SHALL cover: unlock pulse coincident with lock_set[3]=1 -> lock_q=4'b1000.

Source files
------------

// File: rtl/locked_reg_pkg.sv
// rtl/locked_reg_pkg.sv - shared unlock FSM state encoding for the locked register bank
package locked_reg_pkg;

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_KEY0_OK  = 2'd1,
        S_LOCKOUT  = 2'd2,
        S_UNLOCKED = 2'd3
    } unlock_state_e;

endpackage

// File: rtl/unlock_fsm.sv
// rtl/unlock_fsm.sv - two-word key sequencer with wrong-key lockout penalty
// Ports:
//   clk, reset            : clock, synchronous active-high reset
//   key_valid, key_data   : key word strobe and value
//   state                 : current FSM state
//   unlock_pulse          : high in the cycle whose edge enters S_UNLOCKED
module unlock_fsm
    import locked_reg_pkg::*;
#(
    parameter int               WIDTH          = 8,
    parameter logic [WIDTH-1:0] KEY0           = 8'hA5,
    parameter logic [WIDTH-1:0] KEY1           = 8'h3C,
    parameter int               LOCKOUT_CYCLES = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             key_valid,
    input  logic [WIDTH-1:0] key_data,
    output unlock_state_e    state,
    output logic             unlock_pulse
);

    localparam int CW = $clog2(LOCKOUT_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LOAD = CW'(LOCKOUT_CYCLES - 1);

    unlock_state_e   state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;

    // The pulse is combinational so the bank clears its locks on the very
    // edge that moves the FSM into S_UNLOCKED.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        unlock_pulse = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (key_valid) begin
                    if (key_data == KEY0) begin
                        state_d = S_KEY0_OK;
                    end else begin
                        state_d = S_LOCKOUT;
                        cnt_d   = CNT_LOAD;
                    end
                end
            end
            S_KEY0_OK: begin
                if (key_valid) begin
                    if (key_data == KEY1) begin
                        state_d      = S_UNLOCKED;
                        unlock_pulse = 1'b1;
                    end else begin
                        state_d = S_LOCKOUT;
                        cnt_d   = CNT_LOAD;
                    end
                end
            end
            S_LOCKOUT: begin
                // Keys are ignored here; the counter saturates at zero.
                if (cnt_q == '0) begin
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_UNLOCKED: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign state = state_q;

endmodule

// File: rtl/locked_reg_bank.sv
// rtl/locked_reg_bank.sv - register bank with sticky per-register locks and key unlock
// Ports:
//   clk, reset                : clock, synchronous active-high reset
//   wr_en, wr_addr, wr_data   : register write request
//   lock_set                  : per-register sticky lock request
//   key_valid, key_data       : unlock key word strobe and value
//   regs_q                    : flattened register contents, reg i at [i*WIDTH +: WIDTH]
//   lock_q                    : lock bit per register (1 = locked)
//   wr_err                    : one-cycle pulse after a write to a locked register
//   unlock_state              : unlock FSM state encoding
module locked_reg_bank
    import locked_reg_pkg::*;
#(
    parameter int               WIDTH          = 8,
    parameter int               NUM_REGS       = 4,
    parameter logic [WIDTH-1:0] KEY0           = 8'hA5,
    parameter logic [WIDTH-1:0] KEY1           = 8'h3C,
    parameter int               LOCKOUT_CYCLES = 16,
    localparam int              AW             = $clog2(NUM_REGS)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      wr_en,
    input  logic [AW-1:0]             wr_addr,
    input  logic [WIDTH-1:0]          wr_data,
    input  logic [NUM_REGS-1:0]       lock_set,
    input  logic                      key_valid,
    input  logic [WIDTH-1:0]          key_data,
    output logic [NUM_REGS*WIDTH-1:0] regs_q,
    output logic [NUM_REGS-1:0]       lock_q,
    output logic                      wr_err,
    output logic [1:0]                unlock_state
);

    logic [NUM_REGS*WIDTH-1:0] regs_d;
    logic [NUM_REGS-1:0]       lock_d;
    logic                      wr_err_d;
    logic                      unlock_pulse;
    unlock_state_e             fsm_state;

    unlock_fsm #(
        .WIDTH          (WIDTH),
        .KEY0           (KEY0),
        .KEY1           (KEY1),
        .LOCKOUT_CYCLES (LOCKOUT_CYCLES)
    ) u_unlock_fsm (
        .clk          (clk),
        .reset        (reset),
        .key_valid    (key_valid),
        .key_data     (key_data),
        .state        (fsm_state),
        .unlock_pulse (unlock_pulse)
    );

    always_comb begin
        regs_d   = regs_q;
        wr_err_d = 1'b0;
        // lock_set wins over the unlock clear on the same bit.
        lock_d   = lock_set | (lock_q & {NUM_REGS{~unlock_pulse}});
        // Write permission uses the lock bit as it stands this cycle, so a
        // same-cycle lock_set does not block the write that accompanies it.
        if (wr_en) begin
            if (lock_q[wr_addr]) begin
                wr_err_d = 1'b1;
            end else begin
                regs_d[wr_addr*WIDTH +: WIDTH] = wr_data;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            regs_q <= '0;
            lock_q <= '1;
            wr_err <= 1'b0;
        end else begin
            regs_q <= regs_d;
            lock_q <= lock_d;
            wr_err <= wr_err_d;
        end
    end

    assign unlock_state = fsm_state;

endmodule

// File: tb/tb_locked_reg_bank.sv
// tb/tb_locked_reg_bank.sv - directed scoreboard bench for locked_reg_bank
module tb_locked_reg_bank;

    logic        clk = 1'b0;
    logic        reset;
    logic        wr_en;
    logic [1:0]  wr_addr;
    logic [7:0]  wr_data;
    logic [3:0]  lock_set;
    logic        key_valid;
    logic [7:0]  key_data;
    logic [31:0] regs_q;
    logic [3:0]  lock_q;
    logic        wr_err;
    logic [1:0]  unlock_state;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        string       tag;
        logic [63:0] val;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    locked_reg_bank dut (
        .clk          (clk),
        .reset        (reset),
        .wr_en        (wr_en),
        .wr_addr      (wr_addr),
        .wr_data      (wr_data),
        .lock_set     (lock_set),
        .key_valid    (key_valid),
        .key_data     (key_data),
        .regs_q       (regs_q),
        .lock_q       (lock_q),
        .wr_err       (wr_err),
        .unlock_state (unlock_state)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic exp(input string tag, input logic [63:0] val);
        exp_t e;
        e.tag = tag;
        e.val = val;
        sb.push_back(e);
    endtask

    task automatic cmp(input logic [63:0] obs);
        exp_t e;
        checks++;
        if (sb.size() == 0) begin
            failures++;
            $error("FAIL scoreboard_empty observed=%h expected=<entry>", obs);
        end else begin
            e = sb.pop_front();
            assert (obs === e.val) else begin
                failures++;
                $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.val);
            end
        end
    endtask

    task automatic idle_inputs();
        wr_en     = 1'b0;
        wr_addr   = '0;
        wr_data   = '0;
        lock_set  = '0;
        key_valid = 1'b0;
        key_data  = '0;
    endtask

    initial begin
        idle_inputs();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;

        // Reset state
        exp("rst_regs", 64'h0); exp("rst_lock", 64'hF);
        exp("rst_err", 64'h0);  exp("rst_state", 64'h0);
        cmp(64'(regs_q)); cmp(64'(lock_q)); cmp(64'(wr_err)); cmp(64'(unlock_state));

        // Write to a locked register is rejected
        wr_en = 1'b1; wr_addr = 2'd0; wr_data = 8'h11;
        exp("locked_wr_regs", 64'h0); exp("locked_wr_err", 64'h1);
        tick();
        cmp(64'(regs_q)); cmp(64'(wr_err));
        idle_inputs();
        exp("err_one_cycle", 64'h0); exp("lock_all", 64'hF);
        tick();
        cmp(64'(wr_err)); cmp(64'(lock_q));

        // Correct key sequence unlocks everything
        key_valid = 1'b1; key_data = 8'hA5;
        exp("key0_state", 64'h1);
        tick();
        cmp(64'(unlock_state));
        key_data = 8'h3C;
        exp("key1_state", 64'h3); exp("unlock_lock", 64'h0);
        tick();
        cmp(64'(unlock_state)); cmp(64'(lock_q));
        idle_inputs();
        exp("after_unlock_state", 64'h0);
        tick();
        cmp(64'(unlock_state));
        wr_en = 1'b1; wr_addr = 2'd2; wr_data = 8'h22;
        exp("wr_reg2", 64'h0022_0000); exp("wr_reg2_err", 64'h0);
        tick();
        cmp(64'(regs_q)); cmp(64'(wr_err));

        // Same-cycle write and lock_set on an unlocked register
        wr_addr = 2'd1; wr_data = 8'h7E; lock_set = 4'b0010;
        exp("wr_lock_regs", 64'h0022_7E00); exp("wr_lock_lock", 64'h2);
        tick();
        cmp(64'(regs_q)); cmp(64'(lock_q));
        lock_set = 4'b0000; wr_data = 8'h55;
        exp("relock_wr_regs", 64'h0022_7E00); exp("relock_wr_err", 64'h1);
        tick();
        cmp(64'(regs_q)); cmp(64'(wr_err));
        idle_inputs();
        exp("relock_err_clear", 64'h0);
        tick();
        cmp(64'(wr_err));

        // Wrong second key: 16-cycle lockout, keys ignored meanwhile
        key_valid = 1'b1; key_data = 8'hA5;
        exp("lo_key0", 64'h1);
        tick();
        cmp(64'(unlock_state));
        key_data = 8'h00;
        exp("lo_entry", 64'h2);
        tick();
        cmp(64'(unlock_state));
        key_data = 8'hA5;
        for (int i = 0; i < 15; i++) begin
            if (i == 14) key_valid = 1'b0;
            exp($sformatf("lo_hold_%0d", i), 64'h2);
            tick();
            cmp(64'(unlock_state));
        end
        exp("lo_exit", 64'h0); exp("lo_lock_kept", 64'h2);
        tick();
        cmp(64'(unlock_state)); cmp(64'(lock_q));

        // Unlock coincident with lock_set[3]
        key_valid = 1'b1; key_data = 8'hA5;
        exp("pri_key0", 64'h1);
        tick();
        cmp(64'(unlock_state));
        key_data = 8'h3C; lock_set = 4'b1000;
        exp("pri_lock", 64'h8); exp("pri_state", 64'h3);
        tick();
        cmp(64'(lock_q)); cmp(64'(unlock_state));
        idle_inputs();
        tick();

        // Reset during lockout
        key_valid = 1'b1; key_data = 8'h99;
        tick();
        key_valid = 1'b0;
        tick(); tick();
        exp("mid_lo_state", 64'h2);
        cmp(64'(unlock_state));
        reset = 1'b1;
        exp("rst_lo_state", 64'h0); exp("rst_lo_lock", 64'hF); exp("rst_lo_regs", 64'h0);
        tick();
        cmp(64'(unlock_state)); cmp(64'(lock_q)); cmp(64'(regs_q));
        reset = 1'b0;

        // Reset during a key sequence, with KEY1 presented at the same edge
        key_valid = 1'b1; key_data = 8'hA5;
        tick();
        key_data = 8'h3C; reset = 1'b1;
        exp("rst_key_state", 64'h0); exp("rst_key_lock", 64'hF);
        tick();
        cmp(64'(unlock_state)); cmp(64'(lock_q));
        reset = 1'b0;
        exp("post_rst_key1_lockout", 64'h2);
        tick();
        cmp(64'(unlock_state));
        idle_inputs();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
